// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus memory-side responder.
//   hyper_state_e : responder FSM states
//   hyper_ca_t    : field view of the 48-bit command/address word
//   CA_BYTES      : number of CA bytes on the link
//   WRAP_WORDS    : word count of an aligned wrapped-burst group
package hyperbus_pkg;

  localparam int CA_BYTES   = 6;
  localparam int WRAP_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA    = 3'd1,
    ST_LAT   = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_REGW  = 3'd5
  } hyper_state_e;

  // CA[47] read, CA[46] register space, CA[45] linear burst,
  // CA[44:16] upper word address, CA[15:3] reserved, CA[2:0] lower word address.
  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] row_col;
    logic [12:0] rsvd;
    logic [2:0]  col_lo;
  } hyper_ca_t;

endpackage

// File: rtl/hyper_mem_array.sv
// Word storage for the responder: 2^ADDR_WIDTH x 16-bit, no reset.
//   clk   : write clock
//   addr  : shared read/write word address
//   we    : byte enables, we[1] -> bits 15:8, we[0] -> bits 7:0
//   wdata : write data (both lanes)
//   rdata : asynchronous read of mem[addr]
module hyper_mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            we,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  logic [15:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/hyperbus_mem_responder.sv
// HyperRAM-style responder: decodes the 6-byte CA, waits a fixed latency,
// then serves linear or wrapped bursts from an internal word array, or
// reads/writes configuration register CR0.
//   clk_i, rst_ni    : clock (one DDR edge per cycle), async active-low reset
//   hyper_cs_ni      : chip select, active low
//   hyper_dq_i       : DQ byte from the controller
//   hyper_rwds_i     : write mask, 1 masks the byte
//   hyper_dq_o/_oe_o : read byte and its output enable
//   hyper_rwds_o/_oe_o : read strobe (0 during CA = 1x latency) and enable
//   cfg_o            : current CR0
// Transfer semantics: while hyper_cs_ni is low, every cycle carries exactly
// one DQ byte (no stalls). Inbound bytes are valid each cycle of CA, WRITE
// and REGW; an outbound byte is valid in every cycle hyper_dq_oe_o is 1.
// CS high in any state ends the transaction; nothing is committed that cycle.
// LATENCY must be in 1..256 (latency counter is 8 bits).
module hyperbus_mem_responder
  import hyperbus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 12,
  parameter logic [15:0] CFG_RESET  = 16'h8F1F
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hyper_cs_ni,
  input  logic [7:0]  hyper_dq_i,
  input  logic        hyper_rwds_i,
  output logic [7:0]  hyper_dq_o,
  output logic        hyper_dq_oe_o,
  output logic        hyper_rwds_o,
  output logic        hyper_rwds_oe_o,
  output logic [15:0] cfg_o
);

  localparam logic [7:0] CA_LAST   = 8'(CA_BYTES - 1);
  localparam logic [7:0] LAT_LAST  = 8'(LATENCY - 1);
  localparam int         WRAP_BITS = $clog2(WRAP_WORDS);

  hyper_state_e          state_q, state_d;
  logic [39:0]           ca_sh_q;
  logic [7:0]            cnt_q;
  logic                  rw_q, as_q, burst_q, phase_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [WRAP_BITS-1:0]  wrap_lo;
  logic [15:0]           cfg_q, mem_rdata, rd_word;
  logic [1:0]            mem_we;
  logic [7:0]            dq_q;
  logic                  dq_oe_q, rwds_q, rwds_oe_q;
  hyper_ca_t             ca;
  logic [31:0]           ca_addr;
  logic                  unused_ca;

  // Full CA as seen on the cycle of byte 5: five shifted bytes plus the live one.
  assign ca        = hyper_ca_t'({ca_sh_q, hyper_dq_i});
  assign ca_addr   = {ca.row_col, ca.col_lo};
  assign unused_ca = ^{ca.rsvd, ca_addr[31:ADDR_WIDTH]};

  assign wrap_lo   = addr_q[WRAP_BITS-1:0] + WRAP_BITS'(1);
  assign addr_next = burst_q ? addr_q + ADDR_WIDTH'(1)
                             : {addr_q[ADDR_WIDTH-1:WRAP_BITS], wrap_lo};
  assign rd_word   = as_q ? cfg_q : mem_rdata;

  always_comb begin
    state_d = state_q;
    if (hyper_cs_ni) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CA;
        ST_CA:   if (cnt_q == CA_LAST) state_d = (!ca.rw && ca.as) ? ST_REGW : ST_LAT;
        ST_LAT:  if (cnt_q == LAT_LAST) state_d = rw_q ? ST_READ : ST_WRITE;
        default: state_d = state_q;
      endcase
    end
  end

  // phase_q is the lane of the next byte: 0 = word[15:8], 1 = word[7:0].
  always_comb begin
    mem_we = 2'b00;
    if (state_q == ST_WRITE && !hyper_cs_ni && !hyper_rwds_i)
      mem_we = phase_q ? 2'b01 : 2'b10;
  end

  hyper_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk_i),
    .addr  (addr_q),
    .we    (mem_we),
    .wdata ({hyper_dq_i, hyper_dq_i}),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ca_sh_q   <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      as_q      <= 1'b0;
      burst_q   <= 1'b0;
      addr_q    <= '0;
      phase_q   <= 1'b0;
      cfg_q     <= CFG_RESET;
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      rwds_q    <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Enables follow the state being entered, so CS high drops them next cycle.
      dq_oe_q   <= (state_d == ST_READ);
      rwds_oe_q <= (state_d == ST_CA) || (state_d == ST_READ);
      dq_q      <= '0;
      rwds_q    <= 1'b0;
      if (!hyper_cs_ni) begin
        case (state_q)
          ST_IDLE: begin
            ca_sh_q <= {ca_sh_q[31:0], hyper_dq_i};
            cnt_q   <= 8'd1;
          end
          ST_CA: begin
            ca_sh_q <= {ca_sh_q[31:0], hyper_dq_i};
            cnt_q   <= cnt_q + 8'd1;
            if (cnt_q == CA_LAST) begin
              rw_q    <= ca.rw;
              as_q    <= ca.as;
              burst_q <= ca.burst;
              addr_q  <= ca_addr[ADDR_WIDTH-1:0];
              phase_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
          ST_LAT: cnt_q <= cnt_q + 8'd1;
          ST_WRITE: begin
            phase_q <= ~phase_q;
            if (phase_q) addr_q <= addr_next;
          end
          ST_REGW: begin
            // Only the first two bytes load CR0; RWDS is not a mask here.
            if (cnt_q < 8'd2) begin
              if (cnt_q == 8'd0) cfg_q[15:8] <= hyper_dq_i;
              else               cfg_q[7:0]  <= hyper_dq_i;
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
      // Read byte for the next cycle is registered from the current address,
      // including on the last latency cycle, so data starts without a bubble.
      if (state_d == ST_READ) begin
        dq_q    <= phase_q ? rd_word[7:0] : rd_word[15:8];
        rwds_q  <= ~phase_q;
        phase_q <= ~phase_q;
        if (phase_q) addr_q <= addr_next;
      end
    end
  end

  assign hyper_dq_o      = dq_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;
  assign cfg_o           = cfg_q;

endmodule

// File: tb/tb_hyperbus_mem_responder.sv
// Self-checking bench for hyperbus_mem_responder: directed and random
// transactions against a word-array / CR0 reference model.
module tb_hyperbus_mem_responder;

  localparam int AW    = 10;
  localparam int LAT   = 12;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic [7:0]  dq_i = 8'h00;
  logic        rwds_i = 1'b0;
  logic [7:0]  dq_o;
  logic        dq_oe, rwds_o, rwds_oe;
  logic [15:0] cfg_o;

  hyperbus_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .CFG_RESET(16'h8F1F)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .hyper_cs_ni     (cs_n),
    .hyper_dq_i      (dq_i),
    .hyper_rwds_i    (rwds_i),
    .hyper_dq_o      (dq_o),
    .hyper_dq_oe_o   (dq_oe),
    .hyper_rwds_o    (rwds_o),
    .hyper_rwds_oe_o (rwds_oe),
    .cfg_o           (cfg_o)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state and reference model ----------------
  int          errors = 0;
  int          checks = 0;
  bit          mon_off = 1'b0;
  logic        prev_oe = 1'b0;
  logic [8:0]  exp_q[$];    // {rwds, byte}
  int          start_q[$];  // expected cycle of first read byte
  logic [15:0] model_mem[DEPTH];
  logic [15:0] model_cfg = 16'h8F1F;
  logic [7:0]  wdata_q[$];
  logic        wmask_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] make_ca(input logic rw, input logic as, input logic lin,
                                          input logic [31:0] waddr);
    return {rw, as, lin, waddr[31:3], 13'($urandom), waddr[2:0]};
  endfunction

  function automatic int ca_base(input logic [47:0] ca);
    logic [31:0] w;
    w = {ca[44:16], ca[2:0]};
    return int'(w & 32'(DEPTH - 1));
  endfunction

  // Word address of byte i of a burst starting at word base.
  function automatic int model_addr(input logic lin, input int base, input int i);
    if (lin) return (base + i / 2) % DEPTH;
    return (base / 16) * 16 + ((base + i / 2) % 16);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    if (rst_n && !mon_off) begin
      if (dq_oe && !prev_oe) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL burst_start: got burst at cycle %0d expected none", cyc);
        end else begin
          check("first_byte_cycle", 32'(cyc), 32'(start_q.pop_front()));
        end
      end
      if (dq_oe) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_byte: got %0h expected no output", dq_o);
        end else begin
          e = exp_q.pop_front();
          check("read_byte", 32'(dq_o), 32'(e[7:0]));
          check("read_rwds", 32'(rwds_o), 32'(e[8]));
          check("read_rwds_oe", 32'(rwds_oe), 32'd1);
        end
      end
    end
    prev_oe = dq_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic cs, input logic [7:0] d, input logic m);
    cs_n = cs; dq_i = d; rwds_i = m;
    @(posedge clk); #1;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, ca[47-8*i -: 8], 1'b0);
      if (i < 5) begin
        check("ca_rwds_oe", 32'(rwds_oe), 32'd1);
        check("ca_rwds", 32'(rwds_o), 32'd0);
      end
    end
  endtask

  task automatic end_txn();
    step(1'b1, 8'($urandom), 1'($urandom));
    check("idle_dq_oe", 32'(dq_oe), 32'd0);
    check("idle_rwds_oe", 32'(rwds_oe), 32'd0);
  endtask

  // Bytes/masks come from wdata_q/wmask_q; model updated for unmasked bytes.
  task automatic write_burst(input logic [47:0] ca, input int n);
    int a;
    send_ca(ca);
    repeat (LAT) step(1'b0, 8'($urandom), 1'($urandom));
    for (int i = 0; i < n; i++) begin
      step(1'b0, wdata_q[i], wmask_q[i]);
      if (!wmask_q[i]) begin
        a = model_addr(ca[45], ca_base(ca), i);
        if (i % 2 == 0) model_mem[a][15:8] = wdata_q[i];
        else            model_mem[a][7:0]  = wdata_q[i];
      end
    end
    wdata_q.delete();
    wmask_q.delete();
    end_txn();
  endtask

  // n data cycles with CS low; the byte registered before CS is seen high
  // (index n) is also presented, so n+1 bytes are expected.
  task automatic read_burst(input logic [47:0] ca, input int n);
    logic [15:0] w;
    for (int i = 0; i <= n; i++) begin
      w = ca[46] ? model_cfg : model_mem[model_addr(ca[45], ca_base(ca), i)];
      exp_q.push_back((i % 2 == 0) ? {1'b1, w[15:8]} : {1'b0, w[7:0]});
    end
    start_q.push_back(cyc + 6 + LAT);
    send_ca(ca);
    repeat (LAT + n) step(1'b0, 8'($urandom), 1'($urandom));
    end_txn();
  endtask

  task automatic reg_write(input logic [47:0] ca, input logic [15:0] v, input int extra);
    send_ca(ca);
    step(1'b0, v[15:8], 1'($urandom));
    step(1'b0, v[7:0], 1'($urandom));
    repeat (extra) step(1'b0, 8'($urandom), 1'($urandom));
    end_txn();
    model_cfg = v;
    check("cfg_after_regw", 32'(cfg_o), 32'(model_cfg));
  endtask

  task automatic push_w(input logic [7:0] d, input logic m);
    wdata_q.push_back(d);
    wmask_q.push_back(m);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, n;
    logic [31:0] wa;

    repeat (3) @(posedge clk);
    check("rst_cfg", 32'(cfg_o), 32'h8F1F);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (3) step(1'b1, 8'($urandom), 1'b0);
    check("reset_dq", 32'(dq_o), 32'd0);
    check("reset_dq_oe", 32'(dq_oe), 32'd0);
    check("reset_rwds", 32'(rwds_o), 32'd0);
    check("reset_rwds_oe", 32'(rwds_oe), 32'd0);
    check("reset_cfg", 32'(cfg_o), 32'h8F1F);

    // Fill the whole array so every later read has a defined model value.
    for (int i = 0; i < 2 * DEPTH; i++) push_w(8'($urandom), 1'b0);
    write_burst(make_ca(1'b0, 1'b0, 1'b1, 32'd0), 2 * DEPTH);

    // Linear write AA BB CC DD to word 0x12, read back.
    push_w(8'hAA, 1'b0); push_w(8'hBB, 1'b0); push_w(8'hCC, 1'b0); push_w(8'hDD, 1'b0);
    write_burst(48'h2000_0002_0002, 4);
    read_burst(48'hA000_0002_0002, 4);

    // Masked write: low lane keeps BB.
    push_w(8'h11, 1'b0); push_w(8'h22, 1'b1);
    write_burst(48'h2000_0002_0002, 2);
    read_burst(48'hA000_0002_0002, 2);

    // Wrapped read from word 0x1E: 1E, 1F, 10, 11.
    read_burst(48'h8000_0003_0006, 8);

    // Register write with no latency, extra bytes ignored, then register read.
    reg_write(48'h6000_0100_0000, 16'h8F17, 2);
    read_burst(48'hE000_0000_0000, 6);

    // Early deselect after the 3rd byte, then a fresh transaction 1 cycle later.
    read_burst(48'hA000_0002_0002, 3);
    read_burst(make_ca(1'b1, 1'b0, 1'b1, 32'h0000_03FE), 6);

    // Random mix of operations.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      wa   = $urandom;
      n    = $urandom_range(1, 24);
      case (kind)
        0, 1: begin
          for (int i = 0; i < n; i++) push_w(8'($urandom), ($urandom_range(0, 3) == 0));
          write_burst(make_ca(1'b0, 1'b0, 1'($urandom), wa), n);
        end
        2: read_burst(make_ca(1'b1, 1'b0, 1'($urandom), wa), n);
        3: reg_write(make_ca(1'b0, 1'b1, 1'($urandom), wa), 16'($urandom), $urandom_range(0, 2));
        default: read_burst(make_ca(1'b1, 1'b1, 1'($urandom), wa), n);
      endcase
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("start_q_drained", 32'(start_q.size()), 32'd0);

    // Reset in the middle of a read burst clears outputs asynchronously.
    mon_off = 1'b1;
    send_ca(make_ca(1'b1, 1'b0, 1'b1, 32'd0));
    repeat (LAT + 2) step(1'b0, 8'h00, 1'b0);
    check("pre_reset_oe", 32'(dq_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dq_oe", 32'(dq_oe), 32'd0);
    check("async_rst_rwds_oe", 32'(rwds_oe), 32'd0);
    check("async_rst_dq", 32'(dq_o), 32'd0);
    check("async_rst_cfg", 32'(cfg_o), 32'h8F1F);
    cs_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
